// File: rtl/pattern_stream_matcher.sv
// pattern_stream_matcher
// Streaming literal-pattern matcher built on a shift-and bit-vector NFA.
// The pattern is programmed slot by slot while idle. A scan then consumes symbols
// until in_last. Every match start position is reported over valid/ready, and
// overlapping matches are reported too.
// Build option: define PATTERN_WILDCARD_EN to make a '.' (8'h2E) pattern slot
// match any stream symbol. This applies only when DATA_W == 8.
module pattern_stream_matcher #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 8,
    parameter int POS_W   = 16,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DATA_W-1:0] cfg_char,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              match_valid,
    input  logic              match_ready,
    output logic [POS_W-1:0]  match_pos,
    output logic [CNT_W-1:0]  match_count,
    output logic              busy,
    output logic              done
);

    // Only bits 0..MAX_LEN-2 of the NFA state ever feed a later lane.
    localparam int ACT_W = (MAX_LEN > 1) ? MAX_LEN - 1 : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [DATA_W-1:0]  pat_mem [MAX_LEN];
    logic [ACT_W-1:0]   active_reg;
    logic [ACT_W-1:0]   active_next;
    logic [MAX_LEN-1:0] eq;
    logic [MAX_LEN-1:0] nxt;
    logic [MAX_LEN-1:0] last_sel;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   len_clamped;
    logic [POS_W-1:0]   pos_reg;
    logic [POS_W-1:0]   match_pos_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               match_valid_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               accept;
    logic               hit;
    logic               report_taken;

    // A new report may enter whenever the held report is absent or leaves this cycle.
    assign in_ready     = (state_reg == S_RUN) && (!match_valid_reg || match_ready);
    assign accept       = in_valid && in_ready;
    assign report_taken = match_valid_reg && match_ready;
    assign hit          = |(nxt & last_sel);
    assign len_clamped  = (int'(cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;

    assign match_valid = match_valid_reg;
    assign match_pos   = match_pos_reg;
    assign match_count = count_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;

    // Per-slot compare, NFA step, length mask and final-slot select.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_lane
            logic lit_eq;
            assign lit_eq = (in_data == pat_mem[gi]);
`ifdef PATTERN_WILDCARD_EN
            if (DATA_W == 8) begin : g_wild
                assign eq[gi] = lit_eq | (pat_mem[gi] == DATA_W'(8'h2E));
            end else begin : g_lit
                assign eq[gi] = lit_eq;
            end
`else
            assign eq[gi] = lit_eq;
`endif
            if (gi == 0) begin : g_head
                assign nxt[gi] = eq[gi];
            end else begin : g_chain
                assign nxt[gi] = active_reg[gi-1] & eq[gi];
            end
            // len_reg == 0 selects no slot, so an empty pattern never hits.
            assign last_sel[gi] = (int'(len_reg) == gi + 1);
            if (gi < MAX_LEN - 1) begin : g_keep
                assign active_next[gi] = nxt[gi] & (gi < int'(len_reg));
            end
        end
        if (MAX_LEN == 1) begin : g_no_chain
            assign active_next = 1'b0;
        end
    endgenerate

    // Pattern storage: written only while idle, not cleared by reset; start and reset win.
    always_ff @(posedge clk) begin
        if (!reset && state_reg == S_IDLE && cfg_we && !start && int'(cfg_idx) < MAX_LEN) begin
            pat_mem[cfg_idx] <= cfg_char;
        end
    end

    // Scan control FSM with the match report and counters as registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            active_reg      <= '0;
            pos_reg         <= '0;
            len_reg         <= '0;
            match_valid_reg <= 1'b0;
            match_pos_reg   <= '0;
            count_reg       <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        len_reg    <= len_clamped;
                        active_reg <= '0;
                        pos_reg    <= '0;
                        count_reg  <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        active_reg <= active_next;
                        pos_reg    <= pos_reg + POS_W'(1);
                        if (in_last) begin
                            state_reg <= S_FLUSH;
                        end
                    end
                    // A fresh hit overwrites a report that is leaving this cycle.
                    if (accept && hit) begin
                        match_valid_reg <= 1'b1;
                        match_pos_reg   <= pos_reg - POS_W'(len_reg) + POS_W'(1);
                        if (count_reg != {CNT_W{1'b1}}) begin
                            count_reg <= count_reg + CNT_W'(1);
                        end
                    end else if (report_taken) begin
                        match_valid_reg <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (!match_valid_reg || match_ready) begin
                        match_valid_reg <= 1'b0;
                        busy_reg        <= 1'b0;
                        done_reg        <= 1'b1;
                        state_reg       <= S_DONE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pattern_stream_matcher.md
Name: pattern_stream_matcher

Overview:
- Streaming literal-pattern matcher; successor to the single-character `pattern` block, which needed a reset per character and drove one `y` flag.
- Holds a programmable pattern of up to MAX_LEN symbols and scans an unbounded byte stream, one symbol per accepted beat.
- Uses a shift-and bit-vector NFA and reports every match start position, overlapping matches included, over a valid/ready output.
- Sits between the file/stream front end and the match-report logic of the regex engine.

Parameters:
- DATA_W, 8: symbol width in bits.
- MAX_LEN, 8: maximum pattern length in symbols (>=1).
- POS_W, 16: width of the stream position counter and of match_pos.
- CNT_W, 8: width of the saturating match counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  write pattern symbol; honoured only in IDLE.
- cfg_idx  in  $clog2(MAX_LEN)  pattern slot being written.
- cfg_char  in  DATA_W  symbol value for that slot.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length; sampled on start.
- start  in  1  begin a scan; honoured only in IDLE.
- in_valid  in  1  stream symbol valid.
- in_ready  out  1  matcher can accept a symbol.
- in_data  in  DATA_W  stream symbol.
- in_last  in  1  marks the final symbol of the stream.
- match_valid  out  1  match report pending.
- match_ready  in  1  consumer accepts the match report.
- match_pos  out  POS_W  stream index of the first symbol of the match.
- match_count  out  CNT_W  matches found this scan; saturates at all-ones.
- busy  out  1  high in RUN or FLUSH.
- done  out  1  one-cycle pulse when a scan completes.

Behaviour:
- Reset: state=IDLE, active vector=0, pos=0, len_q=0; in_ready=0, match_valid=0, match_pos=0, match_count=0, busy=0, done=0. Pattern RAM contents are unaffected by reset.
- Reset mid-scan aborts immediately. Any pending match report is dropped. Reset wins over every simultaneous input.
- IDLE:
  - cfg_we writes pat[cfg_idx]=cfg_char.
  - On start: len_q=min(cfg_len,MAX_LEN); active, pos and match_count clear; go to RUN. start has priority over a same-cycle cfg_we.
  - start and cfg_we outside IDLE are ignored.
- RUN:
  - in_ready = !match_valid || match_ready.
  - A beat is accepted when in_valid && in_ready.
  - On each accepted symbol c: eq[i]=(c==pat[i]); nxt[0]=eq[0]; nxt[i]=active[i-1]&eq[i]; active<=nxt masked to bits below len_q.
  - Hit when len_q!=0 && nxt[len_q-1]. A hit loads match_valid=1, match_pos=(pos-len_q+1) mod 2^POS_W, and increments match_count (saturating).
  - The report is registered, so match_valid rises the cycle after the final matching symbol is accepted.
  - pos increments by 1 per accepted beat and wraps at 2^POS_W.
  - If match_valid && match_ready coincide with a new hit, the new report replaces the old one with no bubble.
  - match_valid holds until match_ready; match_pos is stable while match_valid=1 && match_ready=0.
  - len_q=0: no symbol ever matches; the stream is still consumed.
- Accepted beat with in_last=1 (after that beat's matching) -> FLUSH.
- FLUSH: in_ready=0. Wait until match_valid=0, or match_valid && match_ready, then -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE. match_count holds until the next start.
- Overlapping matches are all reported. Example: pattern "aa" on stream "aaa" reports positions 0 and 1.

Optional Feature:
- Macro PATTERN_WILDCARD_EN.
- Defined: a pattern slot holding 8'h2E ('.') matches any stream symbol (eq[i]=1). Applies only when DATA_W==8; for other widths the macro has no effect.
- Not defined: 8'h2E is a plain literal and matches only 8'h2E.

Test Plan:
- Pattern "ab", len 2; stream "xabyab" with last on the final symbol, match_ready=1 -> match_pos 1 then 4; match_count=2; done pulses once; in_ready=0 after the last beat.
- Pattern "aa"; stream "aaaa" -> overlapping reports at positions 0, 1, 2; match_count=3.
- Pattern "abc"; stream "abcabc"; hold match_ready=0 for 5 cycles after the first hit -> in_ready=0 while stalled; match_pos stays 0; second report is 3; no symbols lost.
- cfg_len=0, then cfg_len=9 with MAX_LEN=8 and all slots 'z'; stream of 10 'z' -> no matches with len 0; with the clamped len of 8, matches at 0, 1, 2.
- Assert reset mid-scan while match_valid=1 -> next cycle in_ready=0, match_valid=0, busy=0; the pattern RAM still matches after a fresh start.
- With PATTERN_WILDCARD_EN, pattern "a.c"; stream "abcaxc" -> positions 0 and 3. Without the macro -> no match.
